// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter and access sequencer for a single-port
// synchronous RAM with a registered, one-cycle-latency read port.
// Each access runs IDLE -> ACCESS -> (RDWAIT) -> ACK; all RAM controls
// and both acks come straight from flops.
module ram_arbiter #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   // port A
   input  logic                  a_req,
   input  logic                  a_wr,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_ack,
   output logic [DATA_WIDTH-1:0] a_rdata,
   // port B
   input  logic                  b_req,
   input  logic                  b_wr,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_ack,
   output logic [DATA_WIDTH-1:0] b_rdata,
   // RAM side
   output logic                  ram_cs,
   output logic                  ram_oe,
   output logic                  ram_wr,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_q,
   output logic                  busy
);

   typedef enum logic [1:0] {StIdle, StAccess, StRdWait, StAck} state_e;

   state_e                state_q, state_d;
   logic                  owner_q, owner_d;      // 0 = A, 1 = B
   logic                  op_wr_q, op_wr_d;
   logic                  last_b_q, last_b_d;    // 1 = last grant went to B
   logic                  cs_q, cs_d;
   logic                  oe_q, oe_d;
   logic                  wr_q, wr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] din_q, din_d;
   logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
   logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
   logic                  a_ack_q, a_ack_d;
   logic                  b_ack_q, b_ack_d;
   logic                  grant_b;

   // Next-state, arbitration and registered-output decode.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      op_wr_d   = op_wr_q;
      last_b_d  = last_b_q;
      addr_d    = addr_q;
      din_d     = din_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      cs_d      = 1'b0;
      oe_d      = 1'b0;
      wr_d      = 1'b0;
      a_ack_d   = 1'b0;
      b_ack_d   = 1'b0;
      grant_b   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (a_req || b_req) begin
               // Under contention the port that did not win last time goes.
               grant_b  = b_req && (!a_req || !last_b_q);
               owner_d  = grant_b;
               op_wr_d  = grant_b ? b_wr : a_wr;
               addr_d   = grant_b ? b_addr : a_addr;
               din_d    = grant_b ? b_wdata : a_wdata;
               cs_d     = 1'b1;
               wr_d     = op_wr_d;
               oe_d     = !op_wr_d;
               last_b_d = grant_b;
               state_d  = StAccess;
            end
         end
         StAccess: begin
            if (op_wr_q) begin
               a_ack_d = !owner_q;
               b_ack_d = owner_q;
               state_d = StAck;
            end else begin
               state_d = StRdWait;
            end
         end
         StRdWait: begin
            // ram_q is valid this cycle; hand it to the owner with its ack.
            if (owner_q) begin
               b_rdata_d = ram_q;
            end else begin
               a_rdata_d = ram_q;
            end
            a_ack_d = !owner_q;
            b_ack_d = owner_q;
            state_d = StAck;
         end
         StAck: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         owner_q   <= 1'b0;
         op_wr_q   <= 1'b0;
         last_b_q  <= 1'b1;
         cs_q      <= 1'b0;
         oe_q      <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         din_q     <= '0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         op_wr_q   <= op_wr_d;
         last_b_q  <= last_b_d;
         cs_q      <= cs_d;
         oe_q      <= oe_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         din_q     <= din_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
         a_ack_q   <= a_ack_d;
         b_ack_q   <= b_ack_d;
      end
   end

   assign ram_cs   = cs_q;
   assign ram_oe   = oe_q;
   assign ram_wr   = wr_q;
   assign ram_addr = addr_q;
   assign ram_din  = din_q;
   assign a_ack    = a_ack_q;
   assign b_ack    = b_ack_q;
   assign a_rdata  = a_rdata_q;
   assign b_rdata  = b_rdata_q;
   assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a behavioural RAM, a transaction-timeline model of
// the arbiter checked every cycle, and directed scenarios with literal
// expectations.
module tb_ram_arbiter;
   localparam int AW = 16;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          a_req = 1'b0, a_wr = 1'b0, b_req = 1'b0, b_wr = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [DW-1:0] a_wdata = '0, b_wdata = '0;
   logic          a_ack, b_ack, ram_cs, ram_oe, ram_wr, busy;
   logic [DW-1:0] a_rdata, b_rdata, ram_din;
   logic [DW-1:0] ram_q = '0;
   logic [AW-1:0] ram_addr;

   always #5 clk = ~clk;

   ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .ram_cs(ram_cs), .ram_oe(ram_oe), .ram_wr(ram_wr), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_q(ram_q), .busy(busy)
   );

   // Single-port synchronous RAM, registered read.
   logic [DW-1:0] mem [0:65535];
   always @(posedge clk) begin
      if (ram_cs && ram_wr) mem[ram_addr] <= ram_din;
      if (ram_cs && ram_oe) ram_q <= mem[ram_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Timeline model: one transaction at a time, described by the cycle of its
   // arbitration slot, its strobe cycle and its ack cycle.
   bit            m_valid = 1'b0;
   int            m_idle = 0, m_strobe = -1, m_ack = -1;
   bit            m_owner_b = 1'b0, m_wr = 1'b0, m_last_b = 1'b1;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_din = '0, m_rdval = '0, m_a_rdata = '0, m_b_rdata = '0;
   logic [DW-1:0] shadow [0:65535];
   bit            e_cs;

   // Compare DUT against the model each cycle, then advance the model.
   always @(negedge clk) begin
      if (m_valid) begin
         if (cyc == m_ack && !m_wr) begin
            if (m_owner_b) m_b_rdata = m_rdval;
            else m_a_rdata = m_rdval;
         end
         if (cyc == m_strobe && m_wr) shadow[m_addr] = m_din;
         e_cs = (cyc == m_strobe);
         check("ram_cs", 32'(ram_cs), 32'(e_cs));
         check("ram_wr", 32'(ram_wr), 32'(e_cs && m_wr));
         check("ram_oe", 32'(ram_oe), 32'(e_cs && !m_wr));
         if (e_cs) check("ram_addr", 32'(ram_addr), 32'(m_addr));
         if (e_cs && m_wr) check("ram_din", 32'(ram_din), 32'(m_din));
         check("busy", 32'(busy), 32'(m_strobe >= 0 && cyc >= m_strobe && cyc <= m_ack));
         check("a_ack", 32'(a_ack), 32'(cyc == m_ack && !m_owner_b));
         check("b_ack", 32'(b_ack), 32'(cyc == m_ack && m_owner_b));
         check("a_rdata", 32'(a_rdata), 32'(m_a_rdata));
         check("b_rdata", 32'(b_rdata), 32'(m_b_rdata));
      end
      if (reset) begin
         m_valid   = 1'b1;
         m_idle    = cyc + 1;
         m_strobe  = -1;
         m_ack     = -1;
         m_last_b  = 1'b1;
         m_a_rdata = '0;
         m_b_rdata = '0;
      end else if (m_valid && cyc == m_idle) begin
         if (a_req || b_req) begin
            if (a_req && b_req) m_owner_b = !m_last_b;
            else m_owner_b = b_req;
            m_wr     = m_owner_b ? b_wr : a_wr;
            m_addr   = m_owner_b ? b_addr : a_addr;
            m_din    = m_owner_b ? b_wdata : a_wdata;
            m_rdval  = shadow[m_addr];
            m_strobe = cyc + 1;
            m_ack    = cyc + (m_wr ? 2 : 3);
            m_idle   = m_ack + 1;
            m_last_b = m_owner_b;
         end else begin
            m_idle = cyc + 1;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Bounded wait for one port's ack; returns in the cycle after the ack.
   task automatic wait_ack(input bit pb, output int ack_c, output logic [DW-1:0] rd);
      bit got;
      got   = 1'b0;
      ack_c = -1;
      rd    = '0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (pb ? b_ack : a_ack) begin
            got   = 1'b1;
            ack_c = cyc;
            rd    = pb ? b_rdata : a_rdata;
         end
      end
      check(pb ? "b_ack_seen" : "a_ack_seen", 32'(got), 32'(1));
      @(posedge clk);
      #1;
   endtask

   task automatic xfer(input bit pb, input bit wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, output int lat, output logic [DW-1:0] rd);
      int t, ac;
      if (pb) begin
         b_req = 1'b1; b_wr = wr; b_addr = addr; b_wdata = wd;
      end else begin
         a_req = 1'b1; a_wr = wr; a_addr = addr; a_wdata = wd;
      end
      t = cyc;
      wait_ack(pb, ac, rd);
      if (pb) b_req = 1'b0;
      else a_req = 1'b0;
      lat = ac - t;
   endtask

   int            lat, ac_a, ac_b, na, nb, first_b, t0, nacks;
   int            prev_b;
   logic [DW-1:0] rd;

   initial begin
      tick(3);
      reset = 1'b0;
      @(negedge clk);
      check("rst_ram_addr", 32'(ram_addr), 32'h0);
      check("rst_ram_din", 32'(ram_din), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      @(posedge clk);
      #1;

      // A write then read back.
      xfer(1'b0, 1'b1, 16'h1234, 8'hA5, lat, rd);
      check("wr_latency", lat, 2);
      xfer(1'b0, 1'b0, 16'h1234, 8'h00, lat, rd);
      check("rd_latency", lat, 3);
      check("rd_data", 32'(rd), 32'hA5);
      check("b_rdata_hold", 32'(b_rdata), 32'h0);

      // Seed locations read later.
      xfer(1'b0, 1'b1, 16'h0010, 8'h96, lat, rd);
      xfer(1'b0, 1'b1, 16'h0100, 8'h11, lat, rd);
      xfer(1'b0, 1'b1, 16'h0200, 8'h22, lat, rd);

      // Simultaneous requests after reset: A first, then B.
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      a_req = 1'b1; a_wr = 1'b0; a_addr = 16'h0010;
      b_req = 1'b1; b_wr = 1'b1; b_addr = 16'h0020; b_wdata = 8'h5A;
      t0 = cyc;
      wait_ack(1'b0, ac_a, rd);
      a_req = 1'b0;
      check("contend_a_lat", ac_a - t0, 3);
      check("contend_a_data", 32'(rd), 32'h96);
      wait_ack(1'b1, ac_b, rd);
      b_req = 1'b0;
      check("contend_b_gap", ac_b - ac_a, 3);
      xfer(1'b0, 1'b0, 16'h0020, 8'h00, lat, rd);
      check("b_write_readback", 32'(rd), 32'h5A);

      // Both hold requests: strict alternation, B first (A won last).
      a_req = 1'b1; a_wr = 1'b0; a_addr = 16'h0300;
      b_req = 1'b1; b_wr = 1'b1; b_addr = 16'h0300; b_wdata = 8'h3C;
      na = 0; nb = 0; prev_b = -1; first_b = -1;
      for (int i = 0; i < 80 && (na < 4 || nb < 4); i++) begin
         @(negedge clk);
         if (a_ack || b_ack) begin
            if (prev_b >= 0) check("alternate", 32'(b_ack), 32'(prev_b == 0));
            else first_b = int'(b_ack);
            prev_b = int'(b_ack);
            if (a_ack) begin
               na++;
               check("hold_a_data", 32'(a_rdata), 32'h3C);
            end else begin
               nb++;
            end
         end
         @(posedge clk);
         #1;
         if (na >= 4) a_req = 1'b0;
         if (nb >= 4) b_req = 1'b0;
      end
      a_req = 1'b0;
      b_req = 1'b0;
      check("hold_a_count", na, 4);
      check("hold_b_count", nb, 4);
      check("hold_first_is_b", first_b, 1);

      // Reset during RDWAIT of a B read.
      b_req = 1'b1; b_wr = 1'b0; b_addr = 16'h0020;
      tick(2);
      reset = 1'b1;
      b_req = 1'b0;
      tick(1);
      reset = 1'b0;
      @(negedge clk);
      check("rst_mid_cs", 32'(ram_cs), 32'h0);
      check("rst_mid_oe", 32'(ram_oe), 32'h0);
      check("rst_mid_busy", 32'(busy), 32'h0);
      check("rst_mid_b_rdata", 32'(b_rdata), 32'h0);
      nacks = 0;
      for (int i = 0; i < 5; i++) begin
         if (b_ack) nacks++;
         @(negedge clk);
      end
      check("rst_mid_no_b_ack", nacks, 0);
      @(posedge clk);
      #1;
      xfer(1'b0, 1'b1, 16'h0040, 8'h77, lat, rd);
      check("post_rst_wr_lat", lat, 2);

      // B address changes after grant; the latched address is used.
      b_req = 1'b1; b_wr = 1'b0; b_addr = 16'h0100;
      t0 = cyc;
      tick(1);
      b_addr = 16'h0200;
      @(negedge clk);
      check("addr_latched", 32'(ram_addr), 32'h0100);
      wait_ack(1'b1, ac_b, rd);
      b_req = 1'b0;
      check("late_change_lat", ac_b - t0, 3);
      check("late_change_data", 32'(rd), 32'h11);
      nacks = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (b_ack) nacks++;
      end
      check("single_b_ack", nacks, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
